adc_serial_rx: RTL
==================

Name: adc_serial_rx

Overview:
Parametrised receiver for serial ADCs with a chip-select, a serial clock and one or more data lines. All ADC pins are sampled in the system clock domain; the block does not clock logic from the ADC clock. It synchronises the pins, detects frames and the selected serial-clock edge, and shifts DATA_W bits per lane. It presents each completed word in parallel with a one-cycle valid strobe and flags frames that end early. It sits between the ADC pins and the sample-processing logic.

Parameters:
DATA_W, 8, bits per frame per lane (2..32)
NCH, 2, number of parallel data lanes sharing ad_csn/ad_clk (1..8)
MSB_FIRST, 1, 1: first received bit lands in bit DATA_W-1; 0: first bit lands in bit 0
SAMPLE_RISE, 1, 1: sample ad_dat on rising ad_clk; 0: on falling ad_clk
SYNC_STAGES, 2, synchroniser depth applied to every ADC pin (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
ad_csn  in  1  ADC chip select, active low, asynchronous to clk
ad_clk  in  1  ADC serial clock, asynchronous to clk
ad_dat  in  NCH  serial data, one bit per lane
data  out  NCH*DATA_W  last complete word; lane i at data[i*DATA_W +: DATA_W]
valid  out  1  one-cycle pulse when data updates
frame_err  out  1  one-cycle pulse on a short frame
busy  out  1  high while a frame is in progress (state SHIFT or FULL)

Behaviour:
- Reset (async, rst_n=0): data=0, valid=0, frame_err=0, busy=0, state IDLE, bit count 0, shift registers 0.
- Synchroniser reset values: ad_csn flops to 0 (asserted), so a csn already low at reset release never starts a frame. A frame needs csn to be seen high, then low. ad_clk flops reset to SAMPLE_RISE ? 1 : 0, so no spurious sample edge occurs. ad_dat flops reset to 0.
- All pins pass through SYNC_STAGES flops of equal depth, so data stays aligned with the clock edge. An edge is detected by comparing the last synchroniser stage with one extra flop.
- Input timing requirement: ad_clk high and low phases each last at least SYNC_STAGES+1 clk periods. Faster ADC clocks are out of scope.
- States: IDLE, SHIFT, FULL.
- IDLE: on the cycle a csn falling edge is detected, clear the shift registers and bit count and go to SHIFT. A sample edge in that same cycle is not sampled.
- SHIFT, sample edge detected and csn low: shift in one bit per lane and increment the count.
  - MSB_FIRST=1: shift left, new bit at LSB.
  - MSB_FIRST=0: shift right, new bit at MSB.
- SHIFT, count reaching DATA_W: on the next cycle load all lanes into data, pulse valid for one cycle, go to FULL. Valid is therefore high in the cycle after the capture of bit DATA_W-1.
- FULL: further sample edges are ignored; data is held.
- csn rising edge in FULL: go to IDLE with no pulse.
- csn rising edge in SHIFT with count < DATA_W: pulse frame_err for one cycle, leave data unchanged, go to IDLE.
- Simultaneous csn rise and sample edge: the csn rise wins and the edge is ignored.
- csn fall in the same cycle as a transition to IDLE: not possible, because edges are at least 2 cycles apart.
- valid and frame_err never assert in the same cycle.
- Back-to-back frames: a new csn fall after a rise starts a new frame normally. data holds its last value until the next valid.
- Reset mid-frame: the frame is abandoned, with no valid and no frame_err.

Decomposition:
- Package adc_rx_pkg: state enum (IDLE, SHIFT, FULL); localparam CNT_W = $clog2(DATA_W+1); lane-slice helper function.
- One sub-module, adc_sync_edge: a SYNC_STAGES synchroniser with rise/fall detect and a reset-value parameter. Instantiated for ad_csn and ad_clk.
- ad_dat uses a plain synchroniser of the same depth.

Test Plan:
- Defaults, ad_clk period 8 clk cycles, 8 rising edges, lane0 serial 0xA5 and lane1 0x3C MSB first -> data=0x3CA5, exactly one valid pulse, frame_err=0, busy falls after csn rises.
- Short frame of 5 edges, then csn high -> one frame_err pulse, no valid, data remains 0x3CA5.
- Over-long frame of 10 edges with lane0 bits 1,1,1,1,0,0,0,0,1,1 -> lane0=0xF0, one valid, the last two bits ignored, no frame_err.
- MSB_FIRST=0, NCH=1, bits sent 1,0,1,0,0,1,0,1 -> data=0xA5.
- SAMPLE_RISE=0 with data changing on rising edges -> correct word captured on falling edges.
- rst_n pulsed low after 4 bits with csn held low through release -> data=0, no valid or frame_err. 8 more edges are ignored until csn goes high then low. The next good frame of 0x5A on lane0 -> lane0=0x5A with valid.

Source files
------------

// File: rtl/adc_rx_pkg.sv
// rtl/adc_rx_pkg.sv - shared state type and sizing helpers for the serial ADC receiver
package adc_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } rx_state_e;

  // Counter must be able to hold the value DATA_W itself, not just DATA_W-1.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/adc_sync_edge.sv
// rtl/adc_sync_edge.sv - multi-flop synchroniser with rise/fall detection for one ADC pin
module adc_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {STAGES{RST_VAL}};
      last_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~last_q;
  assign fall_o  = ~level_o & last_q;

endmodule

// File: rtl/adc_serial_rx.sv
// rtl/adc_serial_rx.sv - serial ADC frame receiver: pin sync, edge detect, per-lane shift and word output
module adc_serial_rx
  import adc_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NCH         = 2,
  parameter bit MSB_FIRST   = 1'b1,
  parameter bit SAMPLE_RISE = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ad_csn,
  input  logic                  ad_clk,
  input  logic [NCH-1:0]        ad_dat,
  output logic [NCH*DATA_W-1:0] data,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int              CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic csn_lvl, csn_rise, csn_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic smp_edge;

  // csn resets to "asserted" so a chip select already low at reset release is not a frame start.
  adc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_csn_sync (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .din_i  (ad_csn),
    .level_o(csn_lvl),
    .rise_o (csn_rise),
    .fall_o (csn_fall)
  );

  adc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SAMPLE_RISE)) u_sck_sync (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .din_i  (ad_clk),
    .level_o(sck_lvl),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  assign smp_edge = (sck_rise | sck_fall) && (sck_lvl == SAMPLE_RISE);

  // Same depth as the clock synchroniser so each bit lines up with its detected edge.
  logic [SYNC_STAGES-1:0][NCH-1:0] dat_sync_q;
  logic [NCH-1:0]                  dat_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_sync_q <= '0;
    end else begin
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ad_dat};
    end
  end

  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  rx_state_e                     state_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [NCH-1:0][DATA_W-1:0]    shift_q;
  logic [NCH-1:0][DATA_W-1:0]    data_q;
  logic                          valid_q;
  logic                          err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (csn_fall) begin
            shift_q <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q == CNT_FULL) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            state_q <= csn_rise ? IDLE : FULL;
          end else if (csn_rise) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (smp_edge && !csn_lvl) begin
            for (int i = 0; i < NCH; i++) begin
              if (MSB_FIRST) begin
                shift_q[i] <= {shift_q[i][DATA_W-2:0], dat_s[i]};
              end else begin
                shift_q[i] <= {dat_s[i], shift_q[i][DATA_W-1:1]};
              end
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FULL: begin
          if (csn_rise) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign data[lane_lsb(i, DATA_W) +: DATA_W] = data_q[i];
  end

  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule
